// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: PS/2 keys + joystick merge, coin stretch, autofire.
// Optional macro INPUT_SOCD_EN: cancel opposing directions per player.
module arcade_input_mapper #(
   parameter int PLAYERS         = 2,
   parameter int FIRE            = 4,
   parameter int COIN_MIN_CYCLES = 1200000,
   parameter int AUTOFIRE_DIV    = 400000
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   input  logic [10:0]                 ps2_key,
   input  logic [PLAYERS*(FIRE+6)-1:0] joy_in,
   input  logic                        combine,
   input  logic [FIRE-1:0]             autofire_mask,
   output logic [PLAYERS*(FIRE+6)-1:0] btn_out
);

   localparam int W  = FIRE + 6;
   localparam int IS = W - 2;
   localparam int IC = W - 1;
   localparam int NK = 24;
   localparam int CW = (COIN_MIN_CYCLES > 1) ? $clog2(COIN_MIN_CYCLES) : 1;
   localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

   // 12 slots per player: U D L R, fire0..3, start x2, coin x2.
   // Player 1 has a single coin key, so it fills both coin slots.
   localparam logic [7:0] KEYS [NK] = '{
      8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12,
      8'h05, 8'h16, 8'h76, 8'h2E,
      8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h21, 8'h1D,
      8'h06, 8'h1E, 8'h36, 8'h36
   };

   logic              r_tog;
   logic [NK-1:0]     r_key;
   logic [NK-1:0]     w_hit;
   logic              w_evt;
   logic              w_unused;
   logic [W-1:0]      w_kbd [PLAYERS];
   logic [W-1:0]      w_mrg [PLAYERS];
   logic [W-1:0]      w_cmb [PLAYERS];
   logic [W-1:0]      w_nxt [PLAYERS];
   logic [FIRE+3:0]   w_or;
   logic              w_af_any;
   logic [PLAYERS-1:0] r_cprev;
   logic [CW-1:0]     r_ccnt [PLAYERS];
   logic [AW-1:0]     r_af_cnt;
   logic              r_phase;
   logic [PLAYERS*W-1:0] r_out;

   assign w_unused = ps2_key[8];
   assign w_evt    = ps2_key[10] ^ r_tog;
   assign btn_out  = r_out;

   // Match the incoming scan code against every key slot
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NK; i++)
         w_hit[i] = (ps2_key[7:0] == KEYS[i]);
   end

   // Toggle tracking and per-key hold registers
   always_ff @(posedge clk_sys) begin
      r_tog <= ps2_key[10];
      if (reset) begin
         r_key <= '0;
      end else if (w_evt) begin
         for (int i = 0; i < NK; i++)
            if (w_hit[i]) r_key[i] <= ps2_key[9];
      end
   end

   // Build keyboard words for players 0 and 1
   always_comb begin
      for (int p = 0; p < PLAYERS; p++)
         w_kbd[p] = '0;
      for (int p = 0; p < PLAYERS && p < 2; p++) begin
         w_kbd[p][3:0] = r_key[p*12 +: 4];
         for (int k = 0; k < FIRE && k < 4; k++)
            w_kbd[p][4+k] = r_key[p*12+4+k];
         w_kbd[p][IS] = r_key[p*12+8] | r_key[p*12+9];
         w_kbd[p][IC] = r_key[p*12+10] | r_key[p*12+11];
      end
   end

   // Merge keyboard with joystick, then optional all-player combine
   always_comb begin
      w_or = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         w_mrg[p] = w_kbd[p] | joy_in[p*W +: W];
         w_or     = w_or | w_mrg[p][FIRE+3:0];
      end
      for (int p = 0; p < PLAYERS; p++) begin
         w_cmb[p] = w_mrg[p];
         if (combine)
            w_cmb[p][FIRE+3:0] = (p == 0) ? w_or : '0;
      end
      w_af_any = |(w_or[FIRE+3:4] & autofire_mask);
   end

   // Coin pulse stretching, one down-counter per player
   always_ff @(posedge clk_sys) begin
      for (int p = 0; p < PLAYERS; p++) begin
         if (reset) begin
            r_cprev[p] <= 1'b0;
            r_ccnt[p]  <= '0;
         end else begin
            r_cprev[p] <= w_cmb[p][IC];
            if (w_cmb[p][IC] && !r_cprev[p] && r_ccnt[p] == '0)
               r_ccnt[p] <= CW'(COIN_MIN_CYCLES - 1);
            else if (r_ccnt[p] != '0)
               r_ccnt[p] <= r_ccnt[p] - CW'(1);
         end
      end
   end

   // Shared autofire phase; idle state gives an immediate first shot
   always_ff @(posedge clk_sys) begin
      if (reset || !w_af_any) begin
         r_af_cnt <= '0;
         r_phase  <= 1'b1;
      end else if (r_af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
         r_af_cnt <= '0;
         r_phase  <= ~r_phase;
      end else begin
         r_af_cnt <= r_af_cnt + AW'(1);
      end
   end

   // Apply autofire, coin stretch and direction cleanup
   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         w_nxt[p] = w_cmb[p];
         w_nxt[p][FIRE+3:4] =
            (w_cmb[p][FIRE+3:4] & ~autofire_mask) |
            (w_cmb[p][FIRE+3:4] & autofire_mask & {FIRE{r_phase}});
         w_nxt[p][IC] = w_cmb[p][IC] | (r_ccnt[p] != '0);
`ifdef INPUT_SOCD_EN
         if (w_nxt[p][2] && w_nxt[p][3]) begin
            w_nxt[p][2] = 1'b0;
            w_nxt[p][3] = 1'b0;
         end
         if (w_nxt[p][0] && w_nxt[p][1]) begin
            w_nxt[p][0] = 1'b0;
            w_nxt[p][1] = 1'b0;
         end
`endif
      end
   end

   // Output register
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_out <= '0;
      end else begin
         for (int p = 0; p < PLAYERS; p++)
            r_out[p*W +: W] <= w_nxt[p];
      end
   end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed stimulus with a cycle-stamped
// expectation queue checked by an independent monitor.
module tb_arcade_input_mapper;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] ps2_key = '0;
   logic [19:0] joy_in = '0;
   logic        combine = 1'b0;
   logic [3:0]  autofire_mask = '0;
   logic [19:0] btn_out;

   arcade_input_mapper #(
      .PLAYERS(2), .FIRE(4), .COIN_MIN_CYCLES(10), .AUTOFIRE_DIV(4)
   ) dut (
      .clk_sys(clk),
      .reset(reset),
      .ps2_key(ps2_key),
      .joy_in(joy_in),
      .combine(combine),
      .autofire_mask(autofire_mask),
      .btn_out(btn_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       nm;
      logic [19:0] v;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         if (e.cyc < cyc) begin
            n_bad++;
            $display("FAIL %s: slot %0d missed, now %0d", e.nm, e.cyc, cyc);
         end else if (btn_out !== e.v) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at cycle %0d",
                     e.nm, btn_out, e.v, cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_at(input int d, input string nm,
                            input logic [19:0] v);
      exp_t e;
      e.cyc = cyc + d;
      e.nm  = nm;
      e.v   = v;
      q.push_back(e);
   endtask

   task automatic key(input logic pr, input logic [7:0] c);
      ps2_key = {~ps2_key[10], pr, 1'b0, c};
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      expect_at(1, "reset", 20'h0);
      tick(2);

      key(1'b1, 8'h6B);
      expect_at(1, "L_lat", 20'h0);
      expect_at(2, "L_on", 20'h4);
      tick(3);
      key(1'b0, 8'h6B);
      expect_at(1, "L_hold", 20'h4);
      expect_at(2, "L_off", 20'h0);
      tick(3);

      key(1'b1, 8'h99);
      expect_at(2, "unmapped", 20'h0);
      tick(3);

      key(1'b1, 8'h12);
      expect_at(2, "p0_f3", 20'h80);
      tick(3);
      key(1'b0, 8'h12);
      expect_at(2, "p0_f3_off", 20'h0);
      tick(3);

      key(1'b1, 8'h2D);
      expect_at(2, "p1_up", 20'h400);
      tick(3);
      key(1'b0, 8'h2D);
      expect_at(2, "p1_up_off", 20'h0);
      tick(3);

      key(1'b1, 8'h05);
      expect_at(2, "st_a", 20'h100);
      tick(1);
      key(1'b1, 8'h16);
      expect_at(2, "st_b", 20'h100);
      tick(1);
      key(1'b0, 8'h05);
      expect_at(2, "st_keep", 20'h100);
      tick(3);
      expect_at(1, "st_keep2", 20'h100);
      key(1'b0, 8'h16);
      expect_at(2, "st_off", 20'h0);
      tick(3);

      for (int d = 1; d <= 12; d++)
         expect_at(d, $sformatf("coin_d%0d", d),
                   (d <= 10) ? 20'h80000 : 20'h0);
      joy_in = 20'h80000;
      tick(3);
      joy_in = 20'h0;
      tick(2);
      joy_in = 20'h80000;
      tick(1);
      joy_in = 20'h0;
      tick(8);

      autofire_mask = 4'b0001;
      for (int d = 1; d <= 14; d++)
         expect_at(d, $sformatf("af_d%0d", d),
                   (((d - 1) / 4) % 2 == 0) ? 20'h30 : 20'h20);
      expect_at(15, "af_rel", 20'h20);
      expect_at(16, "af_repress", 20'h30);
      expect_at(17, "af_repress2", 20'h30);
      expect_at(18, "af_clr", 20'h0);
      joy_in = 20'h30;
      tick(14);
      joy_in = 20'h20;
      tick(1);
      joy_in = 20'h30;
      tick(2);
      joy_in = 20'h0;
      tick(2);
      autofire_mask = 4'b0000;

      joy_in  = 20'h60400;
      combine = 1'b1;
      expect_at(1, "comb", 20'h40081);
      expect_at(2, "comb2", 20'h40081);
      tick(2);
      combine = 1'b0;
      expect_at(1, "uncomb", 20'h60400);
      tick(2);
      joy_in = 20'h0;
      expect_at(1, "comb_clr", 20'h0);
      tick(2);

      key(1'b1, 8'h6B);
      joy_in = 20'h8;
      expect_at(1, "socd_r", 20'h8);
`ifdef INPUT_SOCD_EN
      expect_at(2, "socd_lr", 20'h0);
`else
      expect_at(2, "socd_lr", 20'hC);
`endif
      tick(2);
      joy_in = 20'h0;
      expect_at(1, "socd_l", 20'h4);
      tick(2);
      key(1'b0, 8'h6B);
      expect_at(2, "socd_off", 20'h0);
      tick(3);

      joy_in = 20'h200;
      expect_at(1, "rcoin1", 20'h200);
      expect_at(2, "rcoin2", 20'h200);
      expect_at(3, "rcoin3", 20'h200);
      expect_at(4, "rcoin_rst", 20'h0);
      tick(1);
      joy_in = 20'h0;
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      expect_at(1, "rcoin_post", 20'h0);
      expect_at(2, "rcoin_post2", 20'h0);
      tick(4);

      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: never checked, slot %0d", e.nm, e.cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
